// File: rtl/hawk_axi_wr_responder.sv
// AXI4 write slave terminating Hawk write-master bursts into a local 512-bit SRAM.
// One burst outstanding; W beats become single-cycle registered SRAM writes with a single B per burst.
module hawk_axi_wr_responder #(
  parameter int                    ID_WIDTH   = 4,
  parameter int                    ADDR_WIDTH = 64,
  parameter int                    DATA_WIDTH = 512,
  parameter int                    LEN_WIDTH  = 8,
  parameter int                    MEM_AW     = 16,
  parameter logic [ADDR_WIDTH-1:0] MEM_BASE   = 64'hFFF6100000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ID_WIDTH-1:0]     s_awid,
  input  logic [ADDR_WIDTH-1:0]   s_awaddr,
  input  logic [LEN_WIDTH-1:0]    s_awlen,
  input  logic [2:0]              s_awsize,
  input  logic [1:0]              s_awburst,
  input  logic                    s_awvalid,
  output logic                    s_awready,
  input  logic [DATA_WIDTH-1:0]   s_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_wstrb,
  input  logic                    s_wlast,
  input  logic                    s_wvalid,
  output logic                    s_wready,
  output logic [ID_WIDTH-1:0]     s_bid,
  output logic [1:0]              s_bresp,
  output logic                    s_bvalid,
  input  logic                    s_bready,
  output logic                    mem_we,
  output logic [MEM_AW-1:0]       mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb
);

  typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

  localparam logic [ADDR_WIDTH:0] MEM_WORDS = (ADDR_WIDTH+1)'(1) << MEM_AW;

  state_t                state, state_nxt;
  logic [ID_WIDTH-1:0]   id_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic                  fixed_q;
  logic                  err_q;
  logic [MEM_AW-1:0]     waddr_q;
  logic [LEN_WIDTH:0]    cnt_q;

  logic                  aw_hs, w_hs, b_hs;
  logic [ADDR_WIDTH-1:0] offset, widx;
  logic [ADDR_WIDTH:0]   end_sum;
  logic                  aw_err;
  logic                  beat_in_len, beat_ok;

  // Address window check: the burst's last word must still land inside the SRAM.
  assign offset  = s_awaddr - MEM_BASE;
  assign widx    = offset >> 6;
  assign end_sum = {1'b0, widx} + {{(ADDR_WIDTH+1-LEN_WIDTH){1'b0}}, s_awlen};
  assign aw_err  = (s_awaddr < MEM_BASE) || (end_sum >= MEM_WORDS) ||
                   (s_awsize != 3'd6) || s_awburst[1];

  assign aw_hs       = s_awvalid & s_awready;
  assign w_hs        = s_wvalid & s_wready;
  assign b_hs        = s_bvalid & s_bready;
  assign beat_in_len = (cnt_q <= {1'b0, len_q});
  assign beat_ok     = !err_q && beat_in_len;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    s_awready = 1'b0;
    s_wready  = 1'b0;
    s_bvalid  = 1'b0;
    case (state)
      IDLE: begin
        s_awready = !rst;
        if (s_awvalid && !rst) state_nxt = DATA;
      end
      DATA: begin
        s_wready = 1'b1;
        if (s_wvalid && s_wlast) state_nxt = RESP;
      end
      RESP: begin
        s_bvalid = 1'b1;
        if (s_bready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign s_bid   = id_q;
  assign s_bresp = (state == RESP && err_q) ? 2'b10 : 2'b00;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_q      <= '0;
      len_q     <= '0;
      fixed_q   <= 1'b0;
      err_q     <= 1'b0;
      waddr_q   <= '0;
      cnt_q     <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else begin
      mem_we <= 1'b0;
      if (aw_hs) begin
        id_q    <= s_awid;
        len_q   <= s_awlen;
        fixed_q <= (s_awburst == 2'b00);
        err_q   <= aw_err;
        waddr_q <= widx[MEM_AW-1:0];
        cnt_q   <= '0;
      end
      if (w_hs) begin
        if (beat_ok) begin
          mem_we    <= 1'b1;
          mem_addr  <= waddr_q;
          mem_wdata <= s_wdata;
          mem_wstrb <= s_wstrb;
        end
        if (!fixed_q) waddr_q <= waddr_q + 1'b1;
        // Saturate so a runaway master cannot wrap back into the legal range.
        if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
        if (!beat_in_len || (s_wlast && cnt_q != {1'b0, len_q})) err_q <= 1'b1;
      end
      if (b_hs) err_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hawk_axi_wr_responder.sv
// Randomized bench for hawk_axi_wr_responder: each burst's writes and response come from
// an address-window/beat-count model and are compared with what the SRAM port and B channel show.
module tb_hawk_axi_wr_responder;
  localparam logic [63:0] MEM_BASE = 64'hFFF6100000;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [3:0]   s_awid = '0;
  logic [63:0]  s_awaddr = '0;
  logic [7:0]   s_awlen = '0;
  logic [2:0]   s_awsize = '0;
  logic [1:0]   s_awburst = '0;
  logic         s_awvalid = 1'b0;
  logic         s_awready;
  logic [511:0] s_wdata = '0;
  logic [63:0]  s_wstrb = '0;
  logic         s_wlast = 1'b0;
  logic         s_wvalid = 1'b0;
  logic         s_wready;
  logic [3:0]   s_bid;
  logic [1:0]   s_bresp;
  logic         s_bvalid;
  logic         s_bready = 1'b0;
  logic         mem_we;
  logic [15:0]  mem_addr;
  logic [511:0] mem_wdata;
  logic [63:0]  mem_wstrb;

  hawk_axi_wr_responder dut (
    .clk(clk), .rst(rst),
    .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
    .s_awburst(s_awburst), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid),
    .s_wready(s_wready),
    .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0]  got_addr[$], exp_addr[$];
  logic [511:0] got_data[$], exp_data[$];
  logic [63:0]  got_strb[$], exp_strb[$];
  int           got_stamp[$], exp_stamp[$];

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      got_addr.push_back(mem_addr);
      got_data.push_back(mem_wdata);
      got_strb.push_back(mem_wstrb);
      got_stamp.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_queues();
    got_addr.delete(); got_data.delete(); got_strb.delete(); got_stamp.delete();
    exp_addr.delete(); exp_data.delete(); exp_strb.delete(); exp_stamp.delete();
  endtask

  task automatic compare_writes(input string tag);
    chk({tag, "_nwrites"}, got_addr.size(), exp_addr.size());
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
      chk({tag, "_addr"},  got_addr[i],  exp_addr[i]);
      chk({tag, "_data"},  got_data[i],  exp_data[i]);
      chk({tag, "_strb"},  got_strb[i],  exp_strb[i]);
      chk({tag, "_stamp"}, got_stamp[i], exp_stamp[i]);
    end
  endtask

  function automatic logic [511:0] rand_data();
    logic [511:0] d;
    for (int k = 0; k < 16; k++) d[k*32 +: 32] = $urandom();
    return d;
  endfunction

  task automatic send_aw(input logic [63:0] addr, input int len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [3:0] id);
    int t;
    @(negedge clk);
    s_awaddr = addr; s_awlen = 8'(len); s_awsize = size; s_awburst = burst; s_awid = id;
    s_awvalid = 1'b1;
    t = 0;
    while (!s_awready && t < 20) begin @(negedge clk); t++; end
    chk("aw_accept", t < 20, 1'b1);
    @(negedge clk);
    s_awvalid = 1'b0;
    chk("wready_after_aw", s_wready, 1'b1);
    chk("awready_in_data", s_awready, 1'b0);
  endtask

  // Drives one complete burst; the model only uses the address window, awsize/awburst
  // legality and the number of beats actually sent versus awlen+1.
  task automatic run_burst(input string tag, input logic [63:0] addr, input int len,
                           input logic [2:0] size, input logic [1:0] burst, input logic [3:0] id,
                           input int nbeats, input int strb_mode, input int gap_max, input int bdly);
    logic         aerr;
    logic [63:0]  word;
    logic [64:0]  last_word;
    logic [1:0]   eresp;
    logic [511:0] d;
    logic [63:0]  s;
    int           t, g;
    word      = (addr - MEM_BASE) >> 6;
    last_word = {1'b0, word} + 65'(len);
    aerr  = (addr < MEM_BASE) || (last_word >= 65'd65536) || (size != 3'd6) || burst[1];
    eresp = (aerr || nbeats != len + 1) ? 2'b10 : 2'b00;
    clear_queues();

    send_aw(addr, len, size, burst, id);
    for (int i = 0; i < nbeats; i++) begin
      g = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
      repeat (g) begin s_wvalid = 1'b0; @(negedge clk); end
      d = rand_data();
      case (strb_mode)
        0:       s = '1;
        1:       s = {4{16'h00FF}};
        default: s = {$urandom(), $urandom()};
      endcase
      s_wdata = d; s_wstrb = s; s_wlast = (i == nbeats - 1); s_wvalid = 1'b1;
      chk({tag, "_wready"}, s_wready, 1'b1);
      if (!aerr && i <= len) begin
        exp_addr.push_back(word[15:0] + ((burst == 2'b01) ? 16'(i) : 16'd0));
        exp_data.push_back(d);
        exp_strb.push_back(s);
        exp_stamp.push_back(cyc + 1);
      end
      @(negedge clk);
    end
    s_wvalid = 1'b0; s_wlast = 1'b0;
    chk({tag, "_bvalid_after_wlast"}, s_bvalid, 1'b1);
    chk({tag, "_wready_in_resp"}, s_wready, 1'b0);

    s_bready = 1'b0;
    repeat (bdly) begin
      chk({tag, "_hold_bvalid"}, s_bvalid, 1'b1);
      chk({tag, "_hold_bid"}, s_bid, id);
      chk({tag, "_hold_bresp"}, s_bresp, eresp);
      chk({tag, "_hold_awready"}, s_awready, 1'b0);
      @(negedge clk);
    end
    s_bready = 1'b1;
    t = 0;
    while (!s_bvalid && t < 20) begin @(negedge clk); t++; end
    chk({tag, "_bvalid"}, s_bvalid, 1'b1);
    chk({tag, "_bid"}, s_bid, id);
    chk({tag, "_bresp"}, s_bresp, eresp);
    @(negedge clk);
    s_bready = 1'b0;
    chk({tag, "_bvalid_clear"}, s_bvalid, 1'b0);
    chk({tag, "_awready_idle"}, s_awready, 1'b1);
    compare_writes(tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_awready"}, s_awready, 1'b0);
    chk({tag, "_wready"},  s_wready, 1'b0);
    chk({tag, "_bvalid"},  s_bvalid, 1'b0);
    chk({tag, "_bid"},     s_bid, 4'd0);
    chk({tag, "_bresp"},   s_bresp, 2'd0);
    chk({tag, "_mem_we"},  mem_we, 1'b0);
    chk({tag, "_mem_addr"}, mem_addr, 16'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 512'd0);
    chk({tag, "_mem_wstrb"}, mem_wstrb, 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] addr;
    int          len, nb, r;
    logic [2:0]  size;
    logic [1:0]  burst;

    #1 rst = 1'b1;
    #1 check_reset_outputs("reset");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1 chk("awready_after_reset", s_awready, 1'b1);

    // W presented with no AW must not be taken.
    @(negedge clk);
    clear_queues();
    s_wdata = rand_data(); s_wstrb = '1; s_wlast = 1'b1; s_wvalid = 1'b1;
    repeat (3) begin
      chk("early_w_wready", s_wready, 1'b0);
      @(negedge clk);
    end
    s_wvalid = 1'b0; s_wlast = 1'b0;
    chk("early_w_nwrites", got_addr.size(), 0);

    run_burst("single", MEM_BASE + 64'h40, 0, 3'd6, 2'b01, 4'd3, 1, 0, 0, 0);
    run_burst("incr4",  MEM_BASE,          3, 3'd6, 2'b01, 4'd7, 4, 2, 0, 1);
    run_burst("fixed",  MEM_BASE + 64'h100, 1, 3'd6, 2'b00, 4'd2, 2, 1, 0, 0);
    run_burst("below",  MEM_BASE - 64'h40, 1, 3'd6, 2'b01, 4'd4, 2, 2, 0, 0);
    run_burst("wlast_early", MEM_BASE + 64'h200, 3, 3'd6, 2'b01, 4'd9, 2, 2, 0, 5);
    run_burst("wlast_late",  MEM_BASE + 64'h400, 1, 3'd6, 2'b01, 4'd1, 3, 2, 0, 0);
    run_burst("top_ok",  MEM_BASE + (64'd65535 << 6), 0, 3'd6, 2'b01, 4'd5, 1, 0, 0, 0);
    run_burst("top_over", MEM_BASE + (64'd65535 << 6), 1, 3'd6, 2'b01, 4'd6, 2, 0, 0, 0);
    run_burst("bad_size", MEM_BASE, 0, 3'd5, 2'b01, 4'd8, 1, 0, 0, 0);
    run_burst("wrap",     MEM_BASE, 1, 3'd6, 2'b10, 4'd10, 2, 0, 0, 0);

    // Asynchronous reset after the second beat of a four-beat burst.
    clear_queues();
    send_aw(MEM_BASE + 64'h80, 3, 3'd6, 2'b01, 4'd11);
    for (int i = 0; i < 2; i++) begin
      s_wdata = rand_data(); s_wstrb = '1; s_wlast = 1'b0; s_wvalid = 1'b1;
      @(negedge clk);
    end
    s_wvalid = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset_outputs("midreset");
    chk("midreset_partial_writes", got_addr.size(), 2);
    repeat (2) @(negedge clk);
    chk("midreset_awready_held", s_awready, 1'b0);
    rst = 1'b0;
    #1 chk("midreset_awready_release", s_awready, 1'b1);
    run_burst("after_reset", MEM_BASE + 64'h80, 3, 3'd6, 2'b01, 4'd12, 4, 2, 0, 0);

    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      if (r < 6)      addr = MEM_BASE + (64'($urandom_range(0, 65535)) << 6) + 64'($urandom_range(0, 63));
      else if (r < 8) addr = MEM_BASE + (64'(65536 - $urandom_range(1, 8)) << 6);
      else if (r < 9) addr = MEM_BASE - 64'($urandom_range(1, 4096));
      else            addr = MEM_BASE + (64'($urandom_range(1, 255)) << 32);
      len   = $urandom_range(0, 7);
      size  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 5)) : 3'd6;
      burst = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
      nb    = len + 1;
      r     = $urandom_range(0, 5);
      if (r == 0) nb = len + 2;
      else if (r == 1 && len > 0) nb = len;
      run_burst("rand", addr, len, size, burst, 4'($urandom_range(0, 15)), nb, 2,
                $urandom_range(0, 2), $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
